// File: rtl/apb3_dbg_pkg.sv
// apb3_dbg_pkg: shared constants and types for the APB3 debug completer.
// Register offsets, DCTRL/DSTATUS bit positions, FSM states, wait-count type.
package apb3_dbg_pkg;

  localparam int unsigned OFF_DCTRL   = 32'h000;
  localparam int unsigned OFF_DSTATUS = 32'h004;
  localparam int unsigned OFF_DPC     = 32'h008;
  localparam int unsigned OFF_SCRATCH = 32'h00C;
  localparam int unsigned OFF_WAITCFG = 32'h010;

  localparam int DCTRL_HALT    = 0;
  localparam int DCTRL_RESUME  = 1;
  localparam int DCTRL_STEP    = 2;
  localparam int DSTAT_HALTED  = 0;
  localparam int DSTAT_RUNNING = 1;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_e;

  typedef logic [3:0] wcnt_t;

endpackage

// File: rtl/apb3_dbg_regfile.sv
// apb3_dbg_regfile: decode, error classification, storage, read mux, W1P pulses.
// In: clk_i, rst_i, paddr_i, pwrite_i, pwdata_i, done_i (completing cycle),
//     cpu_halted_i, cpu_pc_i. Out: rdata_o, err_o, halt_req_o, resume_o,
//     step_o, limit_o (wait-state limit). Macro APB3_DBG_WAITCFG_EN adds WAITCFG.
module apb3_dbg_regfile
  import apb3_dbg_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] paddr_i,
  input  logic                  pwrite_i,
  input  logic [DATA_WIDTH-1:0] pwdata_i,
  input  logic                  done_i,
  input  logic                  cpu_halted_i,
  input  logic [31:0]           cpu_pc_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  err_o,
  output logic                  halt_req_o,
  output logic                  resume_o,
  output logic                  step_o,
  output wcnt_t                 limit_o
);

  logic                  halt_q;
  logic                  resume_q;
  logic                  step_q;
  logic [DATA_WIDTH-1:0] scratch_q;
  logic                  sel_dctrl;
  logic                  sel_scratch;
  logic                  sel_wcfg;
  logic                  hit;
  logic                  ro;
  logic                  wr;

`ifdef APB3_DBG_WAITCFG_EN
  wcnt_t waitcfg_q;
`endif

  // Offsets are word aligned, so a misaligned address never matches an
  // item and lands in the default (unmapped) branch.
  always_comb begin
    hit         = 1'b1;
    ro          = 1'b0;
    sel_dctrl   = 1'b0;
    sel_scratch = 1'b0;
    sel_wcfg    = 1'b0;
    rdata_o     = '0;
    unique case (1'b1)
      paddr_i == ADDR_WIDTH'(OFF_DCTRL): begin
        sel_dctrl           = 1'b1;
        rdata_o[DCTRL_HALT] = halt_q;
      end
      paddr_i == ADDR_WIDTH'(OFF_DSTATUS): begin
        ro                     = 1'b1;
        rdata_o[DSTAT_HALTED]  = cpu_halted_i;
        rdata_o[DSTAT_RUNNING] = !cpu_halted_i;
      end
      paddr_i == ADDR_WIDTH'(OFF_DPC): begin
        ro      = 1'b1;
        rdata_o = DATA_WIDTH'(cpu_pc_i);
      end
      paddr_i == ADDR_WIDTH'(OFF_SCRATCH): begin
        sel_scratch = 1'b1;
        rdata_o     = scratch_q;
      end
`ifdef APB3_DBG_WAITCFG_EN
      paddr_i == ADDR_WIDTH'(OFF_WAITCFG): begin
        sel_wcfg = 1'b1;
        rdata_o  = DATA_WIDTH'(waitcfg_q);
      end
`endif
      default: hit = 1'b0;
    endcase
  end

  assign err_o = !hit || (ro && pwrite_i);
  assign wr    = done_i && pwrite_i && !err_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      halt_q    <= 1'b0;
      resume_q  <= 1'b0;
      step_q    <= 1'b0;
      scratch_q <= '0;
    end else begin
      resume_q <= wr && sel_dctrl && pwdata_i[DCTRL_RESUME];
      step_q   <= wr && sel_dctrl && pwdata_i[DCTRL_STEP];
      if (wr && sel_dctrl) halt_q <= pwdata_i[DCTRL_HALT];
      if (wr && sel_scratch) scratch_q <= pwdata_i;
    end
  end

`ifdef APB3_DBG_WAITCFG_EN
  // New limit lands at the completing edge, so it governs the next transfer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) waitcfg_q <= wcnt_t'(WAIT_STATES);
    else if (wr && sel_wcfg) waitcfg_q <= pwdata_i[3:0];
  end
  assign limit_o = waitcfg_q;
`else
  assign limit_o = wcnt_t'(WAIT_STATES);
`endif

  assign halt_req_o = halt_q;
  assign resume_o   = resume_q;
  assign step_o     = step_q;

endmodule

// File: rtl/apb3_dbg_slave.sv
// apb3_dbg_slave: APB3 completer for the CPU debug port (FSM, wait counter).
// APB: paddr, psel, penable, pwrite, pwdata -> prdata, pready, pslverr.
// Core: cpu_halted, cpu_pc -> dbg_halt_req, dbg_resume, dbg_step.
// Macro APB3_DBG_WAITCFG_EN makes the wait limit programmable (WAITCFG).
module apb3_dbg_slave
  import apb3_dbg_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr,
  input  logic                  cpu_halted,
  input  logic [31:0]           cpu_pc,
  output logic                  dbg_halt_req,
  output logic                  dbg_resume,
  output logic                  dbg_step
);

  state_e                state_q;
  state_e                state_d;
  wcnt_t                 cnt_q;
  wcnt_t                 cnt_d;
  wcnt_t                 limit;
  logic                  rf_err;
  logic [DATA_WIDTH-1:0] rf_rdata;

  apb3_dbg_regfile #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH),
    .WAIT_STATES (WAIT_STATES)
  ) u_rf (
    .clk_i        (clk),
    .rst_i        (rst),
    .paddr_i      (paddr),
    .pwrite_i     (pwrite),
    .pwdata_i     (pwdata),
    .done_i       (pready),
    .cpu_halted_i (cpu_halted),
    .cpu_pc_i     (cpu_pc),
    .rdata_o      (rf_rdata),
    .err_o        (rf_err),
    .halt_req_o   (dbg_halt_req),
    .resume_o     (dbg_resume),
    .step_o       (dbg_step),
    .limit_o      (limit)
  );

  assign pready = (state_q == ACCESS) && psel && penable
                  && (cnt_q == limit);
  assign pslverr = pready && rf_err;
  assign prdata  = (pready && !pwrite && !rf_err) ? rf_rdata : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        // penable without a prior setup phase is ignored here.
        if (psel && !penable) begin
          state_d = ACCESS;
          cnt_d   = '0;
        end
      end
      ACCESS: begin
        // Dropping psel early aborts: pready never rose, so no commit.
        if (!psel || pready) state_d = IDLE;
        else if (cnt_q < limit) cnt_d = cnt_q + wcnt_t'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: doc/apb3_dbg_slave.md
Name: apb3_dbg_slave

Overview:
- APB3 completer (slave) for the CPU debug port; the opposite end of the testbench's APB3 master agent.
- Decodes a small debug register map, inserts programmable wait states, and flags unmapped, misaligned or illegal accesses with PSLVERR.
- Drives halt/resume/step controls into the CPU core and reports core status and PC back to the master.

Parameters:
- ADDR_WIDTH, 12, APB address width.
- DATA_WIDTH, 32, APB data width (only 32 supported).
- WAIT_STATES, 0, access-phase wait cycles before PREADY (0..15).

Ports:
- clk  input  1  single clock.
- rst  input  1  asynchronous, active-high reset.
- paddr  input  ADDR_WIDTH  APB address.
- psel  input  1  select.
- penable  input  1  enable (access phase).
- pwrite  input  1  1 = write.
- pwdata  input  DATA_WIDTH  write data.
- prdata  output  DATA_WIDTH  read data.
- pready  output  1  transfer complete.
- pslverr  output  1  error response, valid only with pready.
- cpu_halted  input  1  core is halted.
- cpu_pc  input  32  current core PC.
- dbg_halt_req  output  1  level halt request to core.
- dbg_resume  output  1  one-cycle resume pulse.
- dbg_step  output  1  one-cycle single-step pulse.

Behaviour:
- Register map (byte offsets, word aligned):
  - 0x000 DCTRL, RW: bit0 halt_req (level); bit1 resume (W1P, reads 0); bit2 step (W1P, reads 0).
  - 0x004 DSTATUS, RO: bit0 halted, bit1 running = !halted.
  - 0x008 DPC, RO: cpu_pc.
  - 0x00C SCRATCH, RW: 32 bits.
- FSM states IDLE and ACCESS:
  - IDLE -> ACCESS when psel && !penable (setup phase seen); wait counter cleared to 0.
  - In ACCESS, the counter increments each cycle while below its limit. The limit is WAIT_STATES, or WAITCFG when the optional feature is compiled in.
  - pready = state==ACCESS && psel && penable && cnt==limit (combinational from registered state).
  - On the completing cycle, the write commits at the clock edge and the FSM returns to IDLE.
  - Back-to-back transfers: IDLE sees the next setup on the following cycle, so there is no bubble beyond the APB3 setup cycle.
  - psel dropping in ACCESS before completion: abort to IDLE, no commit, no pulses.
  - penable high in IDLE with no preceding setup: ignored, and pready stays 0.
- Latency: read/write completes 2+limit cycles after psel rises.
- prdata = read-mux value only on a completing read; 0 otherwise.
- pslverr, asserted only on the completing cycle, for any of:
  - an unmapped offset;
  - paddr[1:0] != 0;
  - a write to DSTATUS or DPC.
- An errored transfer has no register side effect and returns prdata = 0.
- dbg_resume and dbg_step pulse high exactly one cycle after the completing write edge. Writing both bits at once pulses both.
- dbg_halt_req holds DCTRL.bit0. Writing halt_req=1 and resume=1 together sets halt and pulses resume; the core arbitrates.
- DSTATUS and DPC are sampled combinationally on the completing cycle. A cpu_halted change in that cycle is reflected.
- Reset values: prdata=0, pready=0, pslverr=0, dbg_halt_req=0, dbg_resume=0, dbg_step=0, SCRATCH=0, FSM=IDLE, counter=0.
- Reset mid-transfer: immediate return to reset state, and the in-flight write is discarded.

Optional Feature:
- Macro: APB3_DBG_WAITCFG_EN.
- Defined: adds 0x010 WAITCFG, RW, bits[3:0], reset = WAIT_STATES. It sets the wait-state limit for subsequent transfers; a write takes effect from the next transfer, not the current one. Bits[31:4] read 0.
- Undefined: 0x010 is unmapped (pslverr), and the limit is fixed at WAIT_STATES.

Decomposition:
- Package apb3_dbg_pkg: register offset localparams, DCTRL/DSTATUS bit-position constants, the FSM state enum (IDLE, ACCESS), and a 4-bit wait-count type.
- One sub-module, apb3_dbg_regfile: address decode, error classification, register storage, read mux and W1P pulse generation.
- The top holds the FSM, wait counter and handshake outputs.

Test Plan:
- WAIT_STATES=0: write 0xDEADBEEF to 0x00C, then read 0x00C -> pready on the 2nd cycle of each transfer, prdata=0xDEADBEEF, pslverr=0.
- WAIT_STATES=3: read 0x008 with cpu_pc=0x00001000 -> pready low for 3 access cycles, then high with prdata=0x00001000.
- Write 0x6 to 0x000 -> dbg_resume and dbg_step each high exactly one cycle; dbg_halt_req=0; readback of 0x000 = 0x0.
- Error cases, each expecting pslverr=1, prdata=0 and SCRATCH unchanged:
  - write 0x004;
  - read 0x020;
  - read 0x00E (misaligned).
- Assert rst during the access phase of a write 0x1 to 0x000 -> dbg_halt_req stays 0, pready=0; the next transfer completes normally.
- With APB3_DBG_WAITCFG_EN: write 0x2 to 0x010 -> the following read shows 2 wait cycles. Without the macro, the same write returns pslverr=1.
